// File: rtl/fetch_stage.sv
// Y86-64 SEQ fetch: PC register, byte-addressed instruction memory, instruction split and status.
// Latency: decode fields are combinational from the current PC; PC/state/count update on posedge.
// Backpressure: stall holds PC, state and count; a halt or error freezes the stage until reset.
module fetch_stage #(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [63:0] pc_next,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic [2:0]  stat,
    output logic [63:0] instr_count
);
    localparam int unsigned AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [64:0] MEM_END = 65'(IMEM_BYTES);
    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_HLT = 3'd2;
    localparam logic [2:0]  STAT_ADR = 3'd3;
    localparam logic [2:0]  STAT_INS = 3'd4;

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_ERROR} state_t;

    logic [7:0]       mem [IMEM_BYTES];
    logic [9:0][7:0]  fetch_bytes;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] count_q, count_d;
    logic [2:0]  term_stat_q, term_stat_d;

    logic [3:0]  icode_raw, ifun_raw, ra_raw, rb_raw, instr_len;
    logic        need_regids, need_valc, fetch_err;
    logic [63:0] valc_raw, valp_raw;
    logic [64:0] instr_end;
    logic [2:0]  stat_raw;

    // Out-of-range byte lanes read as zero so a fetch at a bad PC decodes as icode 0.
    for (genvar k = 0; k < 10; k++) begin : g_byte
        logic [63:0] byte_addr;
        assign byte_addr      = pc_q + 64'(k);
        assign fetch_bytes[k] = ({1'b0, byte_addr} < MEM_END) ? mem[byte_addr[AW-1:0]] : 8'h00;
    end

    always_comb begin
        icode_raw   = fetch_bytes[0][7:4];
        ifun_raw    = fetch_bytes[0][3:0];
        need_regids = icode_raw inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        need_valc   = icode_raw inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        instr_len   = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
        valp_raw    = pc_q + {60'd0, instr_len};
        // One-past-last byte in 65 bits: a 64-bit wrap lands above MEM_END and flags ADR.
        instr_end   = {1'b0, pc_q} + {61'd0, instr_len};
        fetch_err   = instr_end > MEM_END;
        ra_raw      = need_regids ? fetch_bytes[1][7:4] : 4'hF;
        rb_raw      = need_regids ? fetch_bytes[1][3:0] : 4'hF;
        valc_raw    = 64'd0;
        if (need_valc) begin
            valc_raw = need_regids ? fetch_bytes[9:2] : fetch_bytes[8:1];
        end
        if (fetch_err) begin
            stat_raw = STAT_ADR;
        end else if (icode_raw > 4'hB) begin
            stat_raw = STAT_INS;
        end else if (icode_raw == 4'h0) begin
            stat_raw = STAT_HLT;
        end else begin
            stat_raw = STAT_AOK;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        term_stat_d = term_stat_q;
        if (state_q == S_RUN && !stall) begin
            case (stat_raw)
                STAT_AOK: begin
                    pc_d    = pc_next;
                    count_d = count_q + 64'd1;
                end
                STAT_HLT: begin
                    state_d     = S_HALTED;
                    term_stat_d = STAT_HLT;
                end
                default: begin
                    state_d     = S_ERROR;
                    term_stat_d = stat_raw;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            count_q     <= 64'd0;
            term_stat_q <= STAT_AOK;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            term_stat_q <= term_stat_d;
        end
    end

    // Loader writes proceed regardless of reset or state.
    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < MEM_END)) begin
            mem[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    always_comb begin
        pc          = pc_q;
        instr_count = count_q;
        if (state_q == S_RUN) begin
            icode       = icode_raw;
            ifun        = ifun_raw;
            rA          = ra_raw;
            rB          = rb_raw;
            valC        = valc_raw;
            valP        = valp_raw;
            stat        = stat_raw;
            imem_error  = fetch_err;
            instr_valid = (stat_raw == STAT_AOK);
        end else begin
            icode       = 4'h1;
            ifun        = 4'h0;
            rA          = 4'hF;
            rB          = 4'hF;
            valC        = 64'd0;
            valP        = pc_q;
            stat        = term_stat_q;
            imem_error  = (term_stat_q == STAT_ADR);
            instr_valid = 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: byte-level reference model plus directed scenarios with literal expectations.
module tb_fetch_stage;
    logic        clk, reset, stall, imem_we;
    logic [63:0] pc_next, imem_waddr;
    logic [7:0]  imem_wdata;

    logic [63:0] pc, valC, valP, instr_count;
    logic [3:0]  icode, ifun, rA, rB;
    logic        instr_valid, imem_error;
    logic [2:0]  stat;

    logic [63:0] b_pc, b_valC, b_valP, b_count;
    logic [3:0]  b_icode, b_ifun, b_rA, b_rB;
    logic        b_iv, b_err;
    logic [2:0]  b_stat;

    fetch_stage #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_next(pc_next),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error), .stat(stat),
        .instr_count(instr_count)
    );

    fetch_stage #(.IMEM_BYTES(1024), .RESET_PC(64'd1022)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .pc_next(pc_next),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(b_pc), .icode(b_icode), .ifun(b_ifun), .rA(b_rA), .rB(b_rB), .valC(b_valC),
        .valP(b_valP), .instr_valid(b_iv), .imem_error(b_err), .stat(b_stat),
        .instr_count(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        err;
        logic [2:0]  stat;
    } fx_t;

    logic [7:0]  mm [1024];
    logic [63:0] m_pc, m_cnt;
    int          m_st;      // 0 running, 1 halted, 2 error
    logic [2:0]  m_lat;
    fx_t         cur, nxt;

    function automatic logic [7:0] mbyte(input logic [63:0] a);
        if (a < 64'd1024) return mm[a[9:0]];
        return 8'h00;
    endfunction

    function automatic fx_t model_fetch(input logic [63:0] p);
        fx_t f;
        logic [7:0] b0, b1;
        bit nr, nc;
        int len;
        b0 = mbyte(p);
        b1 = mbyte(p + 64'd1);
        f.icode = b0[7:4];
        f.ifun  = b0[3:0];
        nr = f.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        nc = f.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        len = 1 + (nr ? 1 : 0) + (nc ? 8 : 0);
        f.valp = p + 64'(len);
        f.err = 1'b0;
        for (int k = 0; k < len; k++)
            if (({1'b0, p} + 65'(k)) >= 65'd1024) f.err = 1'b1;
        f.ra = nr ? b1[7:4] : 4'hF;
        f.rb = nr ? b1[3:0] : 4'hF;
        f.valc = 64'd0;
        if (nc)
            for (int k = 0; k < 8; k++)
                f.valc = f.valc | (64'(mbyte(p + 64'(1 + (nr ? 1 : 0) + k))) << (8 * k));
        if (f.err) f.stat = 3'd3;
        else if (f.icode > 4'hB) f.stat = 3'd4;
        else if (f.icode == 4'h0) f.stat = 3'd2;
        else f.stat = 3'd1;
        return f;
    endfunction

    always @(posedge clk) begin
        nxt = model_fetch(m_pc);
        if (reset) begin
            m_pc = 64'd0; m_cnt = 64'd0; m_st = 0; m_lat = 3'd1;
        end else if (m_st == 0 && !stall) begin
            if (nxt.stat == 3'd1) begin
                m_pc = pc_next; m_cnt = m_cnt + 64'd1;
            end else begin
                m_st = (nxt.stat == 3'd2) ? 1 : 2;
                m_lat = nxt.stat;
            end
        end
        if (imem_we && imem_waddr < 64'd1024) mm[imem_waddr[9:0]] = imem_wdata;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cur = model_fetch(m_pc);
            chk("pc", pc, m_pc);
            chk("instr_count", instr_count, m_cnt);
            if (m_st == 0) begin
                chk("icode", 64'(icode), 64'(cur.icode));
                chk("ifun", 64'(ifun), 64'(cur.ifun));
                chk("rA", 64'(rA), 64'(cur.ra));
                chk("rB", 64'(rB), 64'(cur.rb));
                chk("valC", valC, cur.valc);
                chk("valP", valP, cur.valp);
                chk("stat", 64'(stat), 64'(cur.stat));
                chk("imem_error", 64'(imem_error), 64'(cur.err));
                chk("instr_valid", 64'(instr_valid), 64'(cur.stat == 3'd1));
            end else begin
                chk("frozen icode", 64'(icode), 64'h1);
                chk("frozen rA/rB", {56'd0, rA, rB}, 64'hFF);
                chk("frozen valC", valC, 64'd0);
                chk("frozen valP", valP, m_pc);
                chk("frozen stat", 64'(stat), 64'(m_lat));
                chk("frozen imem_error", 64'(imem_error), 64'(m_lat == 3'd3));
                chk("frozen instr_valid", 64'(instr_valid), 64'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        step();
        imem_we = 1'b0;
    endtask

    logic [7:0] prog1 [10] = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        reset = 1'b1; stall = 1'b0; pc_next = 64'd0;
        imem_we = 1'b0; imem_waddr = 64'd0; imem_wdata = 8'h00;
        for (int a = 0; a < 1024; a++) wr(64'(a), 8'h00);
        chk_en = 1'b1;

        // irmovq $10, %rbx
        for (int i = 0; i < 10; i++) wr(64'(i), prog1[i]);
        reset = 1'b0;
        chk("t1 icode", 64'(icode), 64'h3);
        chk("t1 rA/rB", {56'd0, rA, rB}, 64'hF3);
        chk("t1 valC", valC, 64'd10);
        chk("t1 valP", valP, 64'd10);
        chk("t1 stat", 64'(stat), 64'd1);
        chk("t1 instr_valid", 64'(instr_valid), 64'd1);

        // nop then halt, then frozen
        reset = 1'b1;
        wr(64'd0, 8'h10); wr(64'd1, 8'h00);
        reset = 1'b0; pc_next = 64'd1;
        chk("t2 c1 valP", valP, 64'd1);
        step();
        chk("t2 c2 pc", pc, 64'd1);
        chk("t2 c2 stat", 64'(stat), 64'd2);
        pc_next = 64'h40;
        step(); step();
        chk("t2 halted pc", pc, 64'd1);
        chk("t2 halted count", instr_count, 64'd1);
        chk("t2 halted icode", 64'(icode), 64'h1);
        chk("t2 halted stat", 64'(stat), 64'd2);

        // illegal opcode
        reset = 1'b1;
        wr(64'd0, 8'hC0);
        reset = 1'b0;
        chk("t3 stat", 64'(stat), 64'd4);
        chk("t3 instr_valid", 64'(instr_valid), 64'd0);
        step();
        chk("t3 err stat", 64'(stat), 64'd4);
        chk("t3 err pc", pc, 64'd0);
        chk("t3 err icode", 64'(icode), 64'h1);

        // instruction straddling the top of memory (second instance resets to 1022)
        reset = 1'b1;
        wr(64'd1022, 8'h30); wr(64'd1023, 8'hF3);
        reset = 1'b0;
        chk("t4 pc", b_pc, 64'd1022);
        chk("t4 imem_error", 64'(b_err), 64'd1);
        chk("t4 stat", 64'(b_stat), 64'd3);
        chk("t4 instr_valid", 64'(b_iv), 64'd0);
        step();
        chk("t4 err pc", b_pc, 64'd1022);
        chk("t4 err stat", 64'(b_stat), 64'd3);
        chk("t4 err icode", 64'(b_icode), 64'h1);

        // ignored out-of-range write, then jump to the last 64-bit address
        reset = 1'b1;
        wr(64'd0, 8'h10); wr(64'd1024, 8'h00);
        reset = 1'b0; pc_next = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("t7 nop kept", 64'(stat), 64'd1);
        step();
        chk("t7 wrap pc", pc, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t7 wrap stat", 64'(stat), 64'd3);
        chk("t7 wrap icode", 64'(icode), 64'h0);
        step();
        chk("t7 err stat", 64'(stat), 64'd3);

        // stall holds
        reset = 1'b1;
        wr(64'd0, 8'h10); wr(64'd1, 8'h10); wr(64'd2, 8'h10);
        reset = 1'b0; pc_next = 64'd1;
        step();
        stall = 1'b1; pc_next = 64'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5 stall pc", pc, 64'd1);
            chk("t5 stall count", instr_count, 64'd1);
        end
        stall = 1'b0;
        step();
        chk("t5 pc", pc, 64'd2);
        chk("t5 count", instr_count, 64'd2);
        pc_next = 64'd3;
        step();
        stall = 1'b1;
        step();
        chk("t5 stalled halt stat", 64'(stat), 64'd2);
        chk("t5 stalled halt icode", 64'(icode), 64'h0);
        stall = 1'b0;
        step();
        chk("t5 halted icode", 64'(icode), 64'h1);

        // reset out of HALTED
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6 pc", pc, 64'd0);
        chk("t6 count", instr_count, 64'd0);
        chk("t6 stat", 64'(stat), 64'd1);
        pc_next = 64'd1;
        step();
        chk("t6 adv pc", pc, 64'd1);
        chk("t6 adv count", instr_count, 64'd1);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
